// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_detect_pkg;

  localparam int MAX_LEN_DEF = 16;
  localparam int CNT_W_DEF   = 8;
  localparam int LENMASK_W   = 64;

  typedef enum logic {
    FILL   = 1'b0,
    DETECT = 1'b1
  } state_t;

  // Ones in bits [len-1:0]; wide enough for any supported MAX_LEN.
  function automatic logic [LENMASK_W-1:0] lenMask(input int len);
    logic [LENMASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < LENMASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_cfg_regs.sv
// Configuration capture for the pattern detector: latches cfg_* on the load
// strobe and hands the same strobe on as the history/counter clear.
module seq_cfg_regs
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [MAX_LEN-1:0] i_mask,
  input  logic [LEN_W-1:0]   i_len,
  input  logic               i_overlap,
  output logic [MAX_LEN-1:0] o_pattern,
  output logic [MAX_LEN-1:0] o_mask,
  output logic [LEN_W-1:0]   o_len,
  output logic               o_overlap,
  output logic               o_clear
);

  logic [MAX_LEN-1:0] r_pattern;
  logic [MAX_LEN-1:0] r_mask;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern <= '0;
      r_mask    <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
    end else if (i_load) begin
      r_pattern <= i_pattern;
      r_mask    <= i_mask;
      r_len     <= i_len;
      r_overlap <= i_overlap;
    end
  end

  assign o_pattern = r_pattern;
  assign o_mask    = r_mask;
  assign o_len     = r_len;
  assign o_overlap = r_overlap;
  assign o_clear   = i_load;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with programmable pattern, mask and
// length, overlap mode, fill-tracking FSM and saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [MAX_LEN-1:0] cfg_mask,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy_fill
);

  logic [MAX_LEN-1:0] w_cfgPattern;
  logic [MAX_LEN-1:0] w_cfgMask;
  logic [LEN_W-1:0]   w_cfgLen;
  logic               w_cfgOverlap;
  logic               w_clear;

  seq_cfg_regs #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cfg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (cfg_load),
    .i_pattern (cfg_pattern),
    .i_mask    (cfg_mask),
    .i_len     (cfg_len),
    .i_overlap (cfg_overlap),
    .o_pattern (w_cfgPattern),
    .o_mask    (w_cfgMask),
    .o_len     (w_cfgLen),
    .o_overlap (w_cfgOverlap),
    .o_clear   (w_clear)
  );

  // The oldest window bit is only ever compared, never stored again.
  logic [MAX_LEN-2:0] r_history;
  logic [LEN_W-1:0]   r_fill;
  state_t             r_state;
  logic               r_match;
  logic [CNT_W-1:0]   r_cnt;

  logic [MAX_LEN-1:0] w_window;
  logic [LEN_W-1:0]   w_fillNext;
  logic               w_hit;
  logic               w_complete;
  logic               w_accept;

  assign w_window   = {r_history, din};
  assign w_fillNext = r_fill + LEN_W'(1);
  assign w_hit      = (w_cfgLen != '0) &&
                      ((LENMASK_W'((w_window ^ w_cfgPattern) & w_cfgMask) &
                        lenMask(int'(w_cfgLen))) == '0);
  assign w_complete = (r_state == DETECT) || (w_fillNext >= w_cfgLen);
  assign w_accept   = w_hit && w_complete;

  // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_history <= '0;
      r_fill    <= '0;
      r_state   <= FILL;
      r_match   <= 1'b0;
      r_cnt     <= '0;
    end else if (w_clear) begin
      r_history <= '0;
      r_fill    <= '0;
      r_state   <= FILL;
      r_match   <= 1'b0;
      r_cnt     <= '0;
    end else if (din_valid) begin
      r_history <= w_window[MAX_LEN-2:0];
      r_match   <= w_accept;
      if (w_accept && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
      if (w_accept && !w_cfgOverlap) begin
        r_state <= FILL;
        r_fill  <= '0;
      end else if ((r_state == FILL) && (w_cfgLen != '0)) begin
        if (w_complete) begin
          r_state <= DETECT;
          r_fill  <= w_cfgLen;
        end else begin
          r_fill <= w_fillNext;
        end
      end
    end else begin
      r_match <= 1'b0;
    end
  end

  assign match     = r_match;
  assign match_cnt = r_cnt;
  assign busy_fill = (r_state == FILL);

endmodule
